cdc_xfer_arbiter: RTL and testbench



---
 rtl/cdc_xfer_arbiter.sv | 84 ++++++++
 tb/tb_cdc_xfer_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_xfer_arbiter.sv
// cdc_xfer_arbiter: round-robin arbiter sharing one toggle-handshake CDC channel; `CDC_XFER_TIMEOUT_EN adds an ack timeout.
module cdc_xfer_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 16,
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 64,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic [IW-1:0]             grant_id,
  output logic [DATA_W-1:0]         bus_data,
  output logic                      bus_req_tgl,
  input  logic                      bus_ack_tgl,
  output logic [NUM_REQ-1:0]        err
);
  localparam int SW = $clog2(SETUP_CYC + 1);
  typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK} state_t;
  state_t state, state_n;
  logic ack_s1, ack_s2;
  logic [IW-1:0] rr, win, nxt;
  logic [SW-1:0] cnt;
  logic grant, setup_end, ack_hit, timeout;
  // lowest offset from rr wins, so scan from the far end down
  always_comb begin
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[(int'(rr) + k) % NUM_REQ]) win = IW'((int'(rr) + k) % NUM_REQ);
  end
  assign grant     = state == IDLE && ~|done && |req;
  assign setup_end = state == SETUP && cnt == SW'(SETUP_CYC - 1);
  assign ack_hit   = state == WAIT_ACK && ack_s2 == bus_req_tgl;
  assign nxt       = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign busy      = state != IDLE;
`ifdef CDC_XFER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
  assign timeout = state == WAIT_ACK && ack_s2 != bus_req_tgl && to_cnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk)
    if (rst) begin
      to_cnt <= '0;
      err    <= '0;
    end else begin
      to_cnt <= (state == WAIT_ACK) ? to_cnt + 1'b1 : '0;
      err    <= timeout ? NUM_REQ'(1) << grant_id : '0;
    end
`else
  assign timeout = 1'b0;
  assign err     = '0;
`endif
  always_comb begin
    state_n = state;
    state_n = grant ? SETUP : setup_end ? WAIT_ACK : (ack_hit || timeout) ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state       <= IDLE;
      done        <= '0;
      grant_id    <= '0;
      bus_data    <= '0;
      bus_req_tgl <= 1'b0;
      ack_s1      <= 1'b0;
      ack_s2      <= 1'b0;
      rr          <= '0;
      cnt         <= '0;
    end else begin
      state  <= state_n;
      ack_s1 <= bus_ack_tgl;
      ack_s2 <= ack_s1;
      done   <= ack_hit ? NUM_REQ'(1) << grant_id : '0;
      cnt    <= (state == SETUP) ? cnt + 1'b1 : '0;
      if (grant) begin
        grant_id <= win;
        bus_data <= data_in[int'(win)*DATA_W +: DATA_W];
      end
      if (setup_end) bus_req_tgl <= ~bus_req_tgl;
      else if (timeout) bus_req_tgl <= ack_s2;
      if (ack_hit || timeout) rr <= nxt;
    end
endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// tb_cdc_xfer_arbiter: directed checks of arbitration, handshake timing, reset and idle-ack behaviour.
module tb_cdc_xfer_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0;
  logic [63:0] data_in = '0;
  logic [3:0] done, err;
  logic busy, bus_req_tgl, bus_ack_tgl;
  logic [1:0] grant_id;
  logic [15:0] bus_data;
  int total = 0, bad = 0;
  int ack_dly = 3, fcnt = 0;
  bit far_en = 1'b1, kick = 1'b0;

  cdc_xfer_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .done(done), .busy(busy),
    .grant_id(grant_id), .bus_data(bus_data), .bus_req_tgl(bus_req_tgl),
    .bus_ack_tgl(bus_ack_tgl), .err(err)
  );

  always #5 clk = ~clk;

  // far-domain responder: echoes the request toggle ack_dly cycles after seeing it
  always @(posedge clk)
    if (rst) begin
      bus_ack_tgl <= 1'b0;
      fcnt <= 0;
    end else if (kick) bus_ack_tgl <= ~bus_ack_tgl;
    else if (far_en && bus_ack_tgl != bus_req_tgl) begin
      if (fcnt >= ack_dly - 1) begin
        bus_ack_tgl <= bus_req_tgl;
        fcnt <= 0;
      end else fcnt <= fcnt + 1;
    end else fcnt <= 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0;
    tick; tick;
    total += 6;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 4'h0) begin bad++; $display("FAIL reset_done: got %b want 0000", done); end
    if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    if (bus_data !== 16'h0) begin bad++; $display("FAIL reset_bus_data: got %h want 0000", bus_data); end
    if (bus_req_tgl !== 1'b0) begin bad++; $display("FAIL reset_tgl: got %b want 0", bus_req_tgl); end
    if (err !== 4'h0) begin bad++; $display("FAIL reset_err: got %b want 0000", err); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single;
    int n;
    data_in = {16'h4444, 16'h3333, 16'hA5C3, 16'h1111};
    ack_dly = 3; far_en = 1'b1;
    req = 4'b0010;
    tick;
    total += 4;
    if (bus_data !== 16'hA5C3) begin bad++; $display("FAIL single_data: got %h want a5c3", bus_data); end
    if (grant_id !== 2'd1) begin bad++; $display("FAIL single_grant: got %0d want 1", grant_id); end
    if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
    if (bus_req_tgl !== 1'b0) begin bad++; $display("FAIL single_tgl_c1: got %b want 0", bus_req_tgl); end
    tick;
    total++;
    if (bus_req_tgl !== 1'b0) begin bad++; $display("FAIL single_tgl_c2: got %b want 0", bus_req_tgl); end
    tick;
    total++;
    if (bus_req_tgl !== 1'b1) begin bad++; $display("FAIL single_tgl_c3: got %b want 1", bus_req_tgl); end
    n = 3;
    while (done === 4'h0 && n < 30) begin tick; n++; end
    total += 2;
    if (n !== 9) begin bad++; $display("FAIL single_done_cycle: got %0d want 9", n); end
    if (done !== 4'b0010) begin bad++; $display("FAIL single_done: got %b want 0010", done); end
    req = '0;
    tick;
    total++;
    if (done !== 4'h0) begin bad++; $display("FAIL single_done_pulse: got %b want 0000", done); end
    tick;
  endtask

  task automatic test_round_robin;
    int n;
    logic [1:0] exp_id;
    rst = 1'b1; tick; rst = 1'b0;
    ack_dly = 1;
    data_in = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_id = 2'(t % 4);
      n = 0;
      while (done === 4'h0 && n < 40) begin tick; n++; end
      total += 3;
      if (done !== (4'b0001 << exp_id)) begin bad++; $display("FAIL rr_done%0d: got %b want %b", t, done, 4'b0001 << exp_id); end
      if (grant_id !== exp_id) begin bad++; $display("FAIL rr_grant%0d: got %0d want %0d", t, grant_id, exp_id); end
      if (bus_data !== {14'h3400, exp_id}) begin bad++; $display("FAIL rr_data%0d: got %h want %h", t, bus_data, {14'h3400, exp_id}); end
      if (t == 4) req = '0;
      tick;
      total += 2;
      if (done !== 4'h0) begin bad++; $display("FAIL rr_pulse%0d: got %b want 0000", t, done); end
      if (busy !== 1'b0) begin bad++; $display("FAIL rr_dead%0d: got busy %b want 0", t, busy); end
    end
    tick;
  endtask

  task automatic test_stability;
    int n;
    far_en = 1'b0;
    data_in = {16'h1234, 16'h3333, 16'h2222, 16'h1111};
    req = 4'b1000;
    tick;
    data_in = {16'hFFFF, 16'h3333, 16'h2222, 16'h1111};
    for (int i = 0; i < 10; i++) begin
      tick;
      total++;
      if (bus_data !== 16'h1234) begin bad++; $display("FAIL stable_c%0d: got %h want 1234", i, bus_data); end
    end
    far_en = 1'b1;
    n = 0;
    while (done === 4'h0 && n < 40) begin tick; n++; end
    total += 2;
    if (done !== 4'b1000) begin bad++; $display("FAIL stable_done: got %b want 1000", done); end
    if (bus_data !== 16'h1234) begin bad++; $display("FAIL stable_end: got %h want 1234", bus_data); end
    req = '0;
    tick; tick;
    req = 4'b1000;
    tick;
    total++;
    if (bus_data !== 16'hFFFF) begin bad++; $display("FAIL stable_regrant: got %h want ffff", bus_data); end
    n = 0;
    while (done === 4'h0 && n < 40) begin tick; n++; end
    req = '0;
    tick; tick;
  endtask

  task automatic test_early_release;
    int n;
    data_in = {16'h4444, 16'h0BEE, 16'h2222, 16'h1111};
    req = 4'b0100;
    tick;
    total++;
    if (grant_id !== 2'd2) begin bad++; $display("FAIL early_grant: got %0d want 2", grant_id); end
    tick;
    req = '0;
    n = 0;
    while (done === 4'h0 && n < 40) begin tick; n++; end
    total += 2;
    if (done !== 4'b0100) begin bad++; $display("FAIL early_done: got %b want 0100", done); end
    if (bus_data !== 16'h0BEE) begin bad++; $display("FAIL early_data: got %h want 0bee", bus_data); end
    tick; tick;
  endtask

  task automatic test_reset_mid;
    int n, seen;
    far_en = 1'b0;
    data_in = {16'h4444, 16'h3333, 16'h2222, 16'hC0DE};
    req = 4'b0001;
    for (int i = 0; i < 5; i++) tick;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    rst = 1'b1; req = '0;
    tick;
    rst = 1'b0; far_en = 1'b1;
    total += 5;
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (grant_id !== 2'd0) begin bad++; $display("FAIL mid_grant: got %0d want 0", grant_id); end
    if (bus_data !== 16'h0) begin bad++; $display("FAIL mid_data: got %h want 0000", bus_data); end
    if (bus_req_tgl !== 1'b0) begin bad++; $display("FAIL mid_tgl: got %b want 0", bus_req_tgl); end
    if (done !== 4'h0) begin bad++; $display("FAIL mid_done: got %b want 0000", done); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin tick; if (done !== 4'h0) seen++; end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL mid_no_done: got %0d pulses want 0", seen); end
    req = 4'b0001;
    n = 0;
    while (done === 4'h0 && n < 40) begin tick; n++; end
    total += 2;
    if (done !== 4'b0001) begin bad++; $display("FAIL mid_after_done: got %b want 0001", done); end
    if (bus_data !== 16'hC0DE) begin bad++; $display("FAIL mid_after_data: got %h want c0de", bus_data); end
    req = '0;
    tick; tick;
  endtask

  task automatic test_idle_ack;
    int seen;
    far_en = 1'b0;
    kick = 1'b1;
    tick;
    kick = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin tick; if (done !== 4'h0 || busy !== 1'b0) seen++; end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL idle_ack: got %0d active cycles want 0", seen); end
    far_en = 1'b1;
    for (int i = 0; i < 6; i++) tick;
    total++;
    if (done !== 4'h0 || busy !== 1'b0) begin bad++; $display("FAIL idle_ack_restore: got done %b busy %b want 0000 0", done, busy); end
  endtask

`ifdef CDC_XFER_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    rst = 1'b1; far_en = 1'b0; req = '0;
    tick;
    rst = 1'b0;
    data_in = {16'h4444, 16'h3333, 16'hBBBB, 16'hAAAA};
    req = 4'b0011;
    n = 0;
    while (err === 4'h0 && n < 100) begin tick; n++; end
    total += 4;
    if (n !== 67) begin bad++; $display("FAIL to_cycle: got %0d want 67", n); end
    if (err !== 4'b0001) begin bad++; $display("FAIL to_err: got %b want 0001", err); end
    if (done !== 4'h0) begin bad++; $display("FAIL to_done: got %b want 0000", done); end
    if (bus_req_tgl !== 1'b0) begin bad++; $display("FAIL to_tgl: got %b want 0", bus_req_tgl); end
    tick;
    total += 3;
    if (grant_id !== 2'd1) begin bad++; $display("FAIL to_next_grant: got %0d want 1", grant_id); end
    if (bus_data !== 16'hBBBB) begin bad++; $display("FAIL to_next_data: got %h want bbbb", bus_data); end
    if (err !== 4'h0) begin bad++; $display("FAIL to_err_pulse: got %b want 0000", err); end
    far_en = 1'b1;
    n = 0;
    while (done === 4'h0 && n < 40) begin tick; n++; end
    total++;
    if (done !== 4'b0010) begin bad++; $display("FAIL to_next_done: got %b want 0010", done); end
    req = '0;
    tick; tick;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_stability;
    test_early_release;
    test_reset_mid;
    test_idle_ack;
`ifdef CDC_XFER_TIMEOUT_EN
    test_timeout;
`else
    total++;
    if (err !== 4'h0) begin bad++; $display("FAIL err_tied: got %b want 0000", err); end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
